// File: rtl/mcx16_feeder.sv
// Operand scheduler and product collector for the mcx16 serial multiplier.
// Optional build macro ZERO_BYPASS_EN: zero operand pairs complete in IDLE without using the multiplier.
//
// state | meaning
// IDLE  | waiting for a queued operand pair and a free result slot
// RUN   | mul_start held high, waiting for mul_done or the timeout
// GAP   | one cycle with mul_start low so the multiplier re-arms
module mcx16_feeder #(
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT_CYC = 24
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [15:0]                   in_a,
   input  logic [15:0]                   in_b,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [31:0]                   out_prod,
   output logic                          mul_start,
   output logic [15:0]                   mul_ain,
   output logic [15:0]                   mul_bin,
   input  logic [31:0]                   mul_yout,
   input  logic                          mul_done,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [AW:0]   LVL_FULL = (AW + 1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

   state_t        r_state, w_state_nxt;
   logic [15:0]   r_fifo_a [FIFO_DEPTH];
   logic [15:0]   r_fifo_b [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_level;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_base, r_out_prod;
   logic          r_out_valid, r_mul_start, r_err;
   logic [15:0]   r_mul_ain, r_mul_bin;

   logic w_full, w_empty, w_push, w_pop, w_load, w_bypass, w_done_op, w_timeout;

   assign w_full     = (r_level == LVL_FULL);
   assign w_empty    = (r_level == '0);
   assign w_push     = in_valid && !w_full;
   assign in_ready   = !w_full;
   assign fifo_level = r_level;
   assign out_valid  = r_out_valid;
   assign out_prod   = r_out_prod;
   assign mul_start  = r_mul_start;
   assign mul_ain    = r_mul_ain;
   assign mul_bin    = r_mul_bin;
   assign err        = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      w_load      = 1'b0;
      w_bypass    = 1'b0;
      w_done_op   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (!w_empty && !r_out_valid) begin
               w_pop = 1'b1;
`ifdef ZERO_BYPASS_EN
               if (r_fifo_a[r_rd_ptr] == 16'd0 || r_fifo_b[r_rd_ptr] == 16'd0) begin
                  w_bypass = 1'b1;
               end else begin
                  w_load      = 1'b1;
                  w_state_nxt = S_RUN;
               end
`else
               w_load      = 1'b1;
               w_state_nxt = S_RUN;
`endif
            end
         end
         S_RUN: begin
            // A done pulse on the final allowed cycle still wins over the timeout.
            if (mul_done) begin
               w_done_op   = 1'b1;
               w_state_nxt = S_GAP;
            end else if (r_cnt == CNT_LAST) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_GAP;
            end
         end
         S_GAP:   w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_a[r_wr_ptr] <= in_a;
         r_fifo_b[r_wr_ptr] <= in_b;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   // The multiplier's yout never clears, so each product is the delta from the value seen at start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt       <= '0;
         r_base      <= '0;
         r_mul_start <= 1'b0;
         r_mul_ain   <= '0;
         r_mul_bin   <= '0;
         r_out_prod  <= '0;
         r_out_valid <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         if (w_load) begin
            r_cnt       <= '0;
            r_base      <= mul_yout;
            r_mul_start <= 1'b1;
            r_mul_ain   <= r_fifo_a[r_rd_ptr];
            r_mul_bin   <= r_fifo_b[r_rd_ptr];
         end else if (r_state == S_RUN) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_done_op || w_timeout) r_mul_start <= 1'b0;
         if (w_timeout) r_err <= 1'b1;
         if (w_done_op) begin
            r_out_prod  <= mul_yout - r_base;
            r_out_valid <= 1'b1;
         end else if (w_bypass) begin
            r_out_prod  <= '0;
            r_out_valid <= 1'b1;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
      end
   end
endmodule
